// File: rtl/flit_arb_pkg.sv
// Shared constants and state type for the flit send arbiter.
// Flit layout: valid at the MSB, tail just below it, VC field directly below the tail bit.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 16
`endif
`ifndef NUM_VCS
`define NUM_VCS 4
`endif

package flit_arb_pkg;

    localparam int TAIL_BIT = `FLIT_WIDTH - 2;
    localparam int VC_BITS  = (`NUM_VCS > 1) ? $clog2(`NUM_VCS) : 1;
    localparam int VC_LSB   = `FLIT_WIDTH - 2 - VC_BITS;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/flit_send_arbiter_rr_pick.sv
// Rotating-priority selector: one-hot grant for the first eligible index at or
// after rr_ptr, wrapping around to index 0.
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     eligible,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N-1:0]     grant,
    output logic             found
);

    // First pass covers rr_ptr..N-1, second pass wraps to 0..rr_ptr-1.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && eligible[i] && (i >= int'(rr_ptr))) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && eligible[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/flit_send_arbiter.sv
// Round-robin wormhole arbiter sharing one CONNECT send port among NUM_REQ sources.
// Optional FLIT_ARB_PERF_EN adds per-requester grant counters and a send trace.
module flit_send_arbiter
    import flit_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int FLIT_WIDTH = `FLIT_WIDTH,
    parameter int NUM_VCS    = `NUM_VCS
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic [NUM_REQ-1:0][FLIT_WIDTH-1:0] req_flit,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [FLIT_WIDTH-1:0]              put_flit,
    output logic                               put_flit_valid,
    input  logic [NUM_VCS-1:0]                 get_non_full_vcs,
    output logic                               get_non_full_vcs_ready
`ifdef FLIT_ARB_PERF_EN
    ,
    output logic [NUM_REQ-1:0][15:0]           grant_count
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t             state_q, state_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]       lock_id_q, lock_id_d;
    logic [VC_BITS-1:0]     lock_vc_q, lock_vc_d;
    logic [NUM_VCS-1:0]     vc_mask_q, vc_mask_d;
    logic [FLIT_WIDTH-1:0]  put_flit_q, put_flit_d;
    logic                   put_valid_q, put_valid_d;

    logic [NUM_REQ-1:0]     eligible;
    logic [NUM_REQ-1:0]     pick_grant;
    logic                   pick_found;
    logic [PTR_W-1:0]       grant_idx;
    logic                   accept;
    logic [PTR_W-1:0]       acc_id;
    logic [FLIT_WIDTH-1:0]  acc_flit;
    logic [VC_BITS-1:0]     acc_vc;

    // A VC can take a flit when the network reports it non-full and it was not used last cycle.
    function automatic logic vc_open(input logic [VC_BITS-1:0] vc,
                                     input logic [NUM_VCS-1:0] non_full,
                                     input logic [NUM_VCS-1:0] mask);
        vc_open = 1'b0;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (int'(vc) == v) vc_open = non_full[v] & ~mask[v];
        end
    endfunction

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] &
                          vc_open(req_flit[i][VC_LSB +: VC_BITS], get_non_full_vcs, vc_mask_q);
        end
    end

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr_q),
        .grant    (pick_grant),
        .found    (pick_found)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) grant_idx = PTR_W'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_id_d   = lock_id_q;
        lock_vc_d   = lock_vc_q;
        vc_mask_d   = '0;
        put_flit_d  = put_flit_q;
        put_valid_d = 1'b0;
        req_ready   = '0;
        accept      = 1'b0;
        acc_id      = '0;
        acc_flit    = '0;
        acc_vc      = '0;

        if (!RST) begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        req_ready = pick_grant;
                        accept    = 1'b1;
                        acc_id    = grant_idx;
                        acc_flit  = req_flit[grant_idx];
                        acc_vc    = acc_flit[VC_LSB +: VC_BITS];
                        rr_ptr_d  = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
                        if (!acc_flit[TAIL_BIT]) begin
                            state_d   = LOCKED;
                            lock_id_d = grant_idx;
                            lock_vc_d = acc_vc;
                        end
                    end
                end
                // Body flits ride on the head's VC regardless of their own VC field.
                LOCKED: begin
                    if (req_valid[lock_id_q] && vc_open(lock_vc_q, get_non_full_vcs, vc_mask_q)) begin
                        req_ready[lock_id_q] = 1'b1;
                        accept   = 1'b1;
                        acc_id   = lock_id_q;
                        acc_flit = req_flit[lock_id_q];
                        acc_vc   = lock_vc_q;
                        if (acc_flit[TAIL_BIT]) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (accept) begin
            put_valid_d = 1'b1;
            put_flit_d  = acc_flit;
            for (int v = 0; v < NUM_VCS; v++) begin
                vc_mask_d[v] = (int'(acc_vc) == v);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            lock_id_q   <= '0;
            lock_vc_q   <= '0;
            vc_mask_q   <= '0;
            put_flit_q  <= '0;
            put_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_id_q   <= lock_id_d;
            lock_vc_q   <= lock_vc_d;
            vc_mask_q   <= vc_mask_d;
            put_flit_q  <= put_flit_d;
            put_valid_q <= put_valid_d;
        end
    end

    assign put_flit               = put_flit_q;
    assign put_flit_valid         = put_valid_q;
    assign get_non_full_vcs_ready = ~RST;

`ifdef FLIT_ARB_PERF_EN
    logic [NUM_REQ-1:0][15:0] grant_count_q, grant_count_d;
    logic [31:0]              cycle_q, cycle_d;

    // Counters wrap naturally at 16 bits.
    always_comb begin
        grant_count_d = grant_count_q;
        cycle_d       = cycle_q + 32'd1;
        if (accept) grant_count_d[acc_id] = grant_count_q[acc_id] + 16'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            grant_count_q <= '0;
            cycle_q       <= '0;
        end else begin
            grant_count_q <= grant_count_d;
            cycle_q       <= cycle_d;
            if (accept) $display("[ARB] cycle %0d requester %0d flit %h", cycle_q, acc_id, acc_flit);
        end
    end

    assign grant_count = grant_count_q;
`endif

endmodule

// File: tb/tb_flit_send_arbiter.sv
// Scoreboard bench for flit_send_arbiter: a packet-level reference model predicts each
// cycle's grant and the registered send-port output; a negedge monitor checks the port.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 16
`endif
`ifndef NUM_VCS
`define NUM_VCS 4
`endif

module tb_flit_send_arbiter;
    import flit_arb_pkg::*;

    localparam int N  = 4;
    localparam int FW = `FLIT_WIDTH;
    localparam int NV = `NUM_VCS;
    localparam int MAXLEN = 4;

    logic                   CLK = 1'b0;
    logic                   RST = 1'b1;
    logic [N-1:0][FW-1:0]   req_flit = '0;
    logic [N-1:0]           req_valid = '0;
    logic [N-1:0]           req_ready;
    logic [FW-1:0]          put_flit;
    logic                   put_flit_valid;
    logic [NV-1:0]          get_non_full_vcs = '0;
    logic                   get_non_full_vcs_ready;
`ifdef FLIT_ARB_PERF_EN
    logic [N-1:0][15:0]     grant_count;
`endif

    flit_send_arbiter #(
        .NUM_REQ    (N),
        .FLIT_WIDTH (FW),
        .NUM_VCS    (NV)
    ) dut (
        .CLK                    (CLK),
        .RST                    (RST),
        .req_flit               (req_flit),
        .req_valid              (req_valid),
        .req_ready              (req_ready),
        .put_flit               (put_flit),
        .put_flit_valid         (put_flit_valid),
        .get_non_full_vcs       (get_non_full_vcs),
        .get_non_full_vcs_ready (get_non_full_vcs_ready)
`ifdef FLIT_ARB_PERF_EN
        ,
        .grant_count            (grant_count)
`endif
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic          valid;
        logic [FW-1:0] flit;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Source side: each requester holds one packet and offers its flits in order.
    logic [FW-1:0] pkt_mem [N][MAXLEN];
    int            pkt_len [N];
    int            pkt_pos [N];
    logic [N-1:0]  src_en = '0;
    logic [NV-1:0] nf_drive = '0;

    // Reference model state: packet-level view of the arbiter.
    int            m_ptr = 0;
    int            m_lock = -1;
    int            m_lock_vc = 0;
    int            m_last_vc = -1;
    logic [FW-1:0] m_hold = '0;
    int            m_cnt [N];
    int            m_sent3 = 0;

    function automatic int flit_vc(input logic [FW-1:0] f);
        logic [VC_BITS-1:0] v;
        v = f[VC_LSB +: VC_BITS];
        return int'(v);
    endfunction

    function automatic bit vc_ok(input int vc);
        if (vc >= NV) return 1'b0;
        return get_non_full_vcs[vc] && (vc != m_last_vc);
    endfunction

    task automatic load_packet(input int r, input int len, input int vc);
        logic [FW-1:0] f;
        for (int j = 0; j < len; j++) begin
            f = FW'($urandom);
            f[FW-1] = 1'b1;
            f[TAIL_BIT] = (j == len - 1);
            if (j == 0) f[VC_LSB +: VC_BITS] = VC_BITS'(vc);
            pkt_mem[r][j] = f;
        end
        pkt_len[r] = len;
        pkt_pos[r] = 0;
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            pkt_len[i] = 0;
            pkt_pos[i] = 0;
        end
        src_en = '0;
    endtask

    // Predict this cycle's grant from the rules, compare req_ready, and queue the
    // send-port value expected after the coming edge.
    task automatic check_output(input logic rst);
        int            g;
        int            vc;
        logic [N-1:0]  exp_rdy;
        logic [FW-1:0] f;
        exp_t          e;
        g = -1;
        exp_rdy = '0;
        if (!rst) begin
            if (m_lock < 0) begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_ptr + k) % N;
                    if (g < 0 && req_valid[i] && vc_ok(flit_vc(req_flit[i]))) g = i;
                end
            end else if (req_valid[m_lock] && vc_ok(m_lock_vc)) begin
                g = m_lock;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;

        n_vec++;
        if (req_ready !== exp_rdy) begin
            n_err++;
            $display("[TB] FAIL req_ready cycle %0d: got %b expected %b", cyc, req_ready, exp_rdy);
        end
        n_vec++;
        if (get_non_full_vcs_ready !== ~rst) begin
            n_err++;
            $display("[TB] FAIL vcs_ready cycle %0d: got %b expected %b", cyc, get_non_full_vcs_ready, ~rst);
        end

        e.cyc = cyc + 1;
        if (rst) begin
            m_ptr = 0;
            m_lock = -1;
            m_last_vc = -1;
            m_hold = '0;
            for (int i = 0; i < N; i++) begin
                m_cnt[i] = 0;
                pkt_pos[i] = 0;
            end
            e.valid = 1'b0;
            e.flit = '0;
        end else if (g >= 0) begin
            f = req_flit[g];
            vc = (m_lock < 0) ? flit_vc(f) : m_lock_vc;
            if (m_lock < 0) begin
                m_ptr = (g + 1) % N;
                if (!f[TAIL_BIT]) begin
                    m_lock = g;
                    m_lock_vc = vc;
                end
            end else if (f[TAIL_BIT]) begin
                m_lock = -1;
            end
            m_last_vc = vc;
            m_hold = f;
            m_cnt[g]++;
            pkt_pos[g]++;
            if (g == 3) m_sent3++;
            e.valid = 1'b1;
            e.flit = f;
        end else begin
            m_last_vc = -1;
            e.valid = 1'b0;
            e.flit = m_hold;
        end
        sb.push_back(e);
    endtask

    task automatic apply_stimulus(input logic rst);
        @(posedge CLK);
        #1;
        RST = rst;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = src_en[i] && (pkt_pos[i] < pkt_len[i]);
            req_flit[i]  = req_valid[i] ? pkt_mem[i][pkt_pos[i]] : FW'($urandom);
        end
        get_non_full_vcs = nf_drive;
        #1;
        check_output(rst);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) apply_stimulus(1'b0);
    endtask

    task automatic do_reset();
        apply_stimulus(1'b1);
        apply_stimulus(1'b1);
    endtask

    // Monitor: one expected send-port value per cycle, checked at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                n_vec++;
                if (put_flit_valid !== e.valid) begin
                    n_err++;
                    $display("[TB] FAIL put_flit_valid cycle %0d: got %b expected %b", cyc, put_flit_valid, e.valid);
                end
                n_vec++;
                if (put_flit !== e.flit) begin
                    n_err++;
                    $display("[TB] FAIL put_flit cycle %0d: got %h expected %h", cyc, put_flit, e.flit);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        clear_sources();
        nf_drive = '1;
        do_reset();
        apply_stimulus(1'b1);

        $display("[TB] single 3-flit packet on VC0");
        load_packet(0, 3, 0);
        src_en = 4'b0001;
        run(8);

        $display("[TB] four single-flit packets on VCs 0..3");
        do_reset();
        clear_sources();
        for (int i = 0; i < N; i++) load_packet(i, 1, i % NV);
        src_en = 4'b1111;
        run(6);

        $display("[TB] lock holds off a second requester");
        do_reset();
        clear_sources();
        load_packet(1, 4, 1);
        src_en = 4'b0010;
        run(2);
        load_packet(2, 1, 2);
        src_en = 4'b0110;
        run(10);

        $display("[TB] all VCs full, then VC1 opens");
        do_reset();
        clear_sources();
        load_packet(0, 1, 0);
        load_packet(1, 1, 1);
        load_packet(2, 1, 2);
        load_packet(3, 1, 1);
        src_en = 4'b1111;
        nf_drive = '0;
        run(10);
        nf_drive = 4'b0010;
        run(4);
        nf_drive = '1;
        run(4);

        $display("[TB] reset while locked on requester 2");
        do_reset();
        clear_sources();
        load_packet(2, 4, 2);
        src_en = 4'b0100;
        run(2);
        apply_stimulus(1'b1);
        load_packet(0, 1, 0);
        load_packet(2, 1, 2);
        src_en = 4'b0101;
        run(5);

        $display("[TB] randomized traffic");
        do_reset();
        clear_sources();
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                if (pkt_pos[i] >= pkt_len[i] && $urandom_range(0, 3) == 0)
                    load_packet(i, $urandom_range(1, MAXLEN), $urandom_range(0, NV - 1));
            end
            src_en = N'($urandom);
            for (int v = 0; v < NV; v++) nf_drive[v] = ($urandom_range(0, 3) != 0);
            apply_stimulus($urandom_range(0, 299) == 0);
        end
        nf_drive = '1;

`ifdef FLIT_ARB_PERF_EN
        $display("[TB] grant counters after five flits from requester 3");
        do_reset();
        clear_sources();
        m_sent3 = 0;
        src_en = 4'b1000;
        for (int k = 0; k < 40 && m_sent3 < 5; k++) begin
            if (pkt_pos[3] >= pkt_len[3]) load_packet(3, 1, k % NV);
            apply_stimulus(1'b0);
        end
        src_en = '0;
        apply_stimulus(1'b0);
        for (int i = 0; i < N; i++) begin
            int exp_cnt;
            exp_cnt = (i == 3) ? 5 : 0;
            n_vec++;
            if (int'(grant_count[i]) != exp_cnt) begin
                n_err++;
                $display("[TB] FAIL grant_count[%0d]: got %0d expected %0d", i, grant_count[i], exp_cnt);
            end
        end
`endif

        clear_sources();
        run(3);
        @(negedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/flit_send_arbiter.md
# flit_send_arbiter

Round-robin wormhole arbiter that shares one CONNECT network send port among `NUM_REQ` flit sources, e.g. several AXI4 bridges behind one endpoint. The arbiter grants a packet only when the head flit's VC is non-full, then locks onto that source until its tail flit is sent. It drives the network's `putFlit`/`getNonFullVCs` pair directly.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `FLIT_WIDTH`, `` `FLIT_WIDTH ``: flit width.
- `NUM_VCS`, `` `NUM_VCS ``: number of virtual channels.
- `CLK` input 1: clock.
- `RST` input 1: reset. One clock; reset is synchronous and active-high.
- `req_flit` input `NUM_REQ`×`FLIT_WIDTH`: flit offered by each requester.
- `req_valid` input `NUM_REQ`: requester offers a flit.
- `req_ready` output `NUM_REQ`: flit accepted this cycle (combinational grant).
- `put_flit` output `FLIT_WIDTH`: flit to the network send port (registered).
- `put_flit_valid` output 1: enable for `putFlit` (registered).
- `get_non_full_vcs` input `NUM_VCS`: network VC non-full flags.
- `get_non_full_vcs_ready` output 1: enable for `getNonFullVCs`.
- `grant_count` output `NUM_REQ`×16: per-requester flit counters. Present only with `FLIT_ARB_PERF_EN`.

## Operation
- Flit fields:
  - valid = `[FLIT_WIDTH-1]`
  - tail = `[FLIT_WIDTH-2]`
  - VC = `[VC_LSB +: VC_BITS]`, with both constants taken from the package.
- A requester is eligible when `req_valid[i]` is set, the VC of `req_flit[i]` is set in `get_non_full_vcs`, and that VC is not in `vc_mask`.
- FSM states:
  - IDLE: pick the first eligible requester at or after `rr_ptr`, wrapping around. Assert its `req_ready`. If the accepted flit is not a tail, go to LOCKED with `lock_id` = i and `lock_vc` = its VC. `rr_ptr` <= i+1 mod `NUM_REQ` on every accepted head flit, including single-flit packets.
  - LOCKED: only `lock_id` may be granted. Eligibility is checked against `lock_vc`; the VC field of body flits is ignored. Accepting a tail flit returns to IDLE. Other requesters stall.
- `vc_mask`: a one-hot mask of the VC sent in the previous cycle. It covers the one-cycle lag of the network's non-full status. The same VC therefore never receives flits on back-to-back cycles.
- The accepted flit is registered into `put_flit`, and `put_flit_valid` is set the next cycle. Otherwise `put_flit_valid` = 0 and `put_flit` holds its last value.
- `get_non_full_vcs_ready` = ~`RST`.
- At most one `req_ready` bit is high in any cycle.

## Timing
- Reset values: `put_flit_valid` = 0, `put_flit` = 0, `req_ready` = 0, state = IDLE, `rr_ptr` = 0, `vc_mask` = 0, counters = 0.
- Latency: acceptance in cycle t produces `put_flit_valid` in cycle t+1.
- Throughput: one flit per cycle only across different VCs. A single VC gets at most one flit every 2 cycles.
- All VCs full: no grant, FSM state held, and `rr_ptr` unchanged.
- Reset mid-packet drops the lock immediately. The requester must restart the packet.
- `req_valid` falling while LOCKED is legal; the lock is held.
- Counters wrap at 0xFFFF.

## Configuration
- `FLIT_ARB_PERF_EN` defined: `grant_count[i]` increments on each flit accepted from requester i. A `$display` prints cycle, requester, and flit on each send.
- Not defined: no `grant_count` port, no counters, no display.

## Structure
- Package `flit_arb_pkg` holds `TAIL_BIT`, `VC_LSB`, `VC_BITS`, and the FSM state enum `arb_state_t` (IDLE, LOCKED).
- Sub-module `rr_pick`: combinational rotating-priority selector. Inputs are the eligibility vector and `rr_ptr`; outputs are a one-hot grant and a found flag.
- Top module holds the FSM, `vc_mask`, output register, and counters.

## Test plan
- Single requester 0 sends a 3-flit packet on VC0 with all VCs non-full:
  - flits appear on cycles t+1, t+3, and t+5, because of the VC0 mask;
  - `req_ready[0]` is high on t, t+2, and t+4.
- Requesters 0–3 each send single-flit packets on distinct VCs 0..3 at once:
  - grants go 0,1,2,3 on consecutive cycles;
  - `rr_ptr` ends at 0.
- Requester 1 is mid-packet (LOCKED) when requester 2 raises valid:
  - requester 2 is not granted until requester 1's tail is accepted;
  - requester 2 is granted in the following cycle.
- `get_non_full_vcs` = 0 for 10 cycles with all requesters valid:
  - no `req_ready`, `put_flit_valid` = 0;
  - when VC1 goes non-full, the first requester at or after `rr_ptr` with a VC1 flit is granted.
- Assert `RST` while LOCKED on requester 2, then release:
  - outputs are 0 next cycle, state = IDLE;
  - requester 0 is granted first.
- With `FLIT_ARB_PERF_EN`: after 5 flits from requester 3, `grant_count[3]` = 5 and other counters = 0.
